// File: rtl/param_updown_counter.sv
// Parametrised loadable up/down counter with wrap or saturate at the boundaries.
// It drives a one-cycle terminal-count pulse and a sticky overflow flag.
module param_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             SAT_C  = (SAT_MODE != 0);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    // Set while the counter is parked at a boundary in saturate mode, so tc fires only once.
    logic             hold_q, hold_d;
    logic             bnd_s;

    // Next-state: load beats count; boundary events pulse tc and set ovf.
    always_comb begin
        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q;
        hold_d = 1'b0;
        bnd_s  = 1'b0;
        if (load) begin
            cnt_d = (data_in > MAX_C) ? MAX_C : data_in;
        end else if (en) begin
            if (up_dn) begin
                if (cnt_q == MAX_C) begin
                    bnd_s = 1'b1;
                    cnt_d = SAT_C ? MAX_C : ZERO_C;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end else begin
                if (cnt_q == ZERO_C) begin
                    bnd_s = 1'b1;
                    cnt_d = SAT_C ? ZERO_C : MAX_C;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end

        // A boundary event outranks a simultaneous clear of ovf.
        if (bnd_s) begin
            tc_d   = ~(SAT_C & hold_q);
            ovf_d  = 1'b1;
            hold_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
        end else begin
            ovf_d  = ovf_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= ZERO_C;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
            hold_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
            hold_q <= hold_d;
        end
    end

    assign data_out = cnt_q;
    assign tc       = tc_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench: a wrapping MAX_VAL=9 counter and a saturating MAX_VAL=15 counter
// share one stimulus stream and are checked against an integer reference model every cycle.
module tb_param_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] w_out, s_out;
    logic       w_tc, w_ovf, s_tc, s_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        int cnt;
        bit tc;
        bit ovf;
        bit parked;
    } model_t;

    model_t mw, ms;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(0)) dut_w (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en),
        .up_dn(up_dn), .clr_ovf(clr_ovf), .data_out(w_out), .tc(w_tc), .ovf(w_ovf)
    );

    param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .SAT_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .en(en),
        .up_dn(up_dn), .clr_ovf(clr_ovf), .data_out(s_out), .tc(s_tc), .ovf(s_ovf)
    );

    // Reference: plain integer count; leaving 0..max is a boundary event.
    function automatic model_t step(input int max, input bit sat, input model_t cur,
                                    input bit ld, input int d, input bit e, input bit u,
                                    input bit clr);
        model_t nx;
        int     t;
        bit     hit;
        nx        = cur;
        nx.tc     = 1'b0;
        nx.parked = 1'b0;
        hit       = 1'b0;
        if (ld) begin
            nx.cnt = (d > max) ? max : d;
        end else if (e) begin
            t = u ? cur.cnt + 1 : cur.cnt - 1;
            if (t > max || t < 0) begin
                hit    = 1'b1;
                nx.cnt = sat ? cur.cnt : (u ? 0 : max);
            end else begin
                nx.cnt = t;
            end
        end
        if (hit) begin
            nx.tc     = !(sat && cur.parked);
            nx.ovf    = 1'b1;
            nx.parked = 1'b1;
        end else if (clr) begin
            nx.ovf = 1'b0;
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw <= '0;
            ms <= '0;
        end else begin
            mw <= step(9, 1'b0, mw, load, int'(data_in), en, up_dn, clr_ovf);
            ms <= step(15, 1'b1, ms, load, int'(data_in), en, up_dn, clr_ovf);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model, away from the clock edge.
    always @(negedge clk) begin
        chk("w_data_out", int'(w_out), mw.cnt);
        chk("w_tc", int'(w_tc), int'(mw.tc));
        chk("w_ovf", int'(w_ovf), int'(mw.ovf));
        chk("s_data_out", int'(s_out), ms.cnt);
        chk("s_tc", int'(s_tc), int'(ms.tc));
        chk("s_ovf", int'(s_ovf), int'(ms.ovf));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit ld, input int d, input bit e, input bit u, input bit clr);
        load    = ld;
        data_in = 4'(d);
        en      = e;
        up_dn   = u;
        clr_ovf = clr;
    endtask

    int exp_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int tog_exp [4]  = '{6, 5, 6, 5};
    int sat_up  [3]  = '{15, 15, 15};
    int sat_tc  [3]  = '{0, 1, 0};

    initial begin
        drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        chk("reset_out", int'(w_out), 0);
        chk("reset_tc", int'(w_tc), 0);
        chk("reset_ovf", int'(w_ovf), 0);

        // Wrap up through 9 -> 0.
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("wrap_up_out", int'(w_out), exp_seq[i]);
            chk("wrap_up_tc", int'(w_tc), (i == 9) ? 1 : 0);
            chk("wrap_up_ovf", int'(w_ovf), (i >= 9) ? 1 : 0);
        end

        // Wrap down from 0, then clear ovf while idle.
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("wrap_dn_out", int'(w_out), 9);
        chk("wrap_dn_tc", int'(w_tc), 1);
        chk("wrap_dn_ovf", int'(w_ovf), 1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("clr_ovf", int'(w_ovf), 0);
        chk("clr_tc", int'(w_tc), 0);

        // Clamp on load beats en, then count down from the clamp.
        drive(1'b1, 12, 1'b1, 1'b1, 1'b0);
        tick();
        chk("clamp_out", int'(w_out), 9);
        chk("clamp_tc", int'(w_tc), 0);
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("after_clamp", int'(w_out), 8);

        // Clear on the same edge as a wrap: set wins.
        drive(1'b1, 9, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("set_wins_out", int'(w_out), 0);
        chk("set_wins_tc", int'(w_tc), 1);
        chk("set_wins_ovf", int'(w_ovf), 1);

        // Direction toggling every cycle from 5.
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 0, 1'b1, (i % 2 == 0), 1'b0);
            tick();
            chk("toggle_out", int'(w_out), tog_exp[i]);
            chk("toggle_tc", int'(w_tc), 0);
        end

        // Saturating counter: park at 15 and at 0, tc pulses once.
        drive(1'b1, 14, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_up_out", int'(s_out), sat_up[i]);
            chk("sat_up_tc", int'(s_tc), sat_tc[i]);
        end
        chk("sat_up_ovf", int'(s_ovf), 1);
        drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sat_dn_out0", int'(s_out), 0);
        chk("sat_dn_tc0", int'(s_tc), 1);
        tick();
        chk("sat_dn_out1", int'(s_out), 0);
        chk("sat_dn_tc1", int'(s_tc), 0);

        // Asynchronous reset mid-count, observed before the next edge.
        drive(1'b1, 5, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_out", int'(w_out), 0);
        chk("async_rst_tc", int'(w_tc), 0);
        chk("async_rst_ovf", int'(w_ovf), 0);
        chk("async_rst_s_ovf", int'(s_ovf), 0);
        tick();
        rst = 1'b1;

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
